// File: rtl/rtc_bus_driver.sv
// Cycle-level timing generator for the RTC chip's multiplexed CS#/RD#/WR#/A-D# bus.
// One request runs address phase, data phase, a one-cycle fin pulse and a recovery gap.
module rtc_bus_driver #(
  parameter int unsigned T_SU  = 1,
  parameter int unsigned T_PW  = 4,
  parameter int unsigned T_HD  = 1,
  parameter int unsigned T_REC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activa,
  input  logic       escribe,
  input  logic [7:0] dir_in,
  input  logic [7:0] data_in,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] data_rd,
  output logic       fin,
  output logic       busy,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_A_SU = 4'd1,
    S_A_PW = 4'd2,
    S_A_HD = 4'd3,
    S_D_SU = 4'd4,
    S_D_PW = 4'd5,
    S_D_HD = 4'd6,
    S_DONE = 4'd7,
    S_REC  = 4'd8
  } state_e;

  localparam logic [3:0] SU_M1  = 4'(T_SU - 1);
  localparam logic [3:0] PW_M1  = 4'(T_PW - 1);
  localparam logic [3:0] HD_M1  = 4'(T_HD - 1);
  localparam logic [3:0] REC_M1 = 4'(T_REC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dat_q, dat_d;
  logic       esc_q, esc_d;
  logic [7:0] data_rd_q, data_rd_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic       fin_q, fin_d;
  logic       busy_q, busy_d;
  logic       in_bus;
  logic       last;

  // Next-state logic; the counter holds (length-1) on entry and counts down to 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    dat_d     = dat_q;
    esc_d     = esc_q;
    data_rd_d = data_rd_q;
    last      = (cnt_q == 4'd0);
    in_bus    = (state_q inside {S_A_SU, S_A_PW, S_A_HD, S_D_SU, S_D_PW, S_D_HD});

    if (in_bus && !activa) begin
      state_d = S_REC;
      cnt_d   = REC_M1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = 4'd0;
          if (activa) begin
            dir_d   = dir_in;
            dat_d   = data_in;
            esc_d   = escribe;
            state_d = S_A_SU;
            cnt_d   = SU_M1;
          end
        end
        S_A_SU: if (last) begin state_d = S_A_PW; cnt_d = PW_M1; end else cnt_d = cnt_q - 4'd1;
        S_A_PW: if (last) begin state_d = S_A_HD; cnt_d = HD_M1; end else cnt_d = cnt_q - 4'd1;
        S_A_HD: if (last) begin state_d = S_D_SU; cnt_d = SU_M1; end else cnt_d = cnt_q - 4'd1;
        S_D_SU: if (last) begin state_d = S_D_PW; cnt_d = PW_M1; end else cnt_d = cnt_q - 4'd1;
        S_D_PW: begin
          if (last) begin
            state_d = S_D_HD;
            cnt_d   = HD_M1;
            if (!esc_q) data_rd_d = ad_in;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_D_HD: if (last) begin state_d = S_DONE; cnt_d = 4'd0; end else cnt_d = cnt_q - 4'd1;
        S_DONE: begin
          state_d = S_REC;
          cnt_d   = REC_M1;
        end
        S_REC: if (last) begin state_d = S_IDLE; cnt_d = 4'd0; end else cnt_d = cnt_q - 4'd1;
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so every pin is a flop.
  always_comb begin
    ad_out_d = 8'h00;
    ad_oe_d  = 1'b0;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b0;
    fin_d    = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_A_SU, S_A_PW, S_A_HD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = dir_d;
        wr_n_d   = (state_d != S_A_PW);
      end
      S_D_SU, S_D_PW, S_D_HD: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b1;
        ad_oe_d  = esc_d;
        ad_out_d = esc_d ? dat_d : 8'h00;
        wr_n_d   = !((state_d == S_D_PW) && esc_d);
        rd_n_d   = !((state_d == S_D_PW) && !esc_d);
      end
      S_DONE:  fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      dir_q     <= 8'h00;
      dat_q     <= 8'h00;
      esc_q     <= 1'b0;
      data_rd_q <= 8'h00;
      ad_out_q  <= 8'h00;
      ad_oe_q   <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_q     <= 1'b0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      dat_q     <= dat_d;
      esc_q     <= esc_d;
      data_rd_q <= data_rd_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      a_d_q     <= a_d_d;
      fin_q     <= fin_d;
      busy_q    <= busy_d;
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign a_d       = a_d_q;
  assign data_rd   = data_rd_q;
  assign fin       = fin_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Bench for rtc_bus_driver: per-cycle vector tables for write/read, directed
// sequences for chaining, abort, reset and minimum-timing parameters.
module tb_rtc_bus_driver;

  logic       clk = 1'b0;
  logic       reset, activa, activa2, escribe;
  logic [7:0] dir_in, data_in, ad_in;

  logic [7:0] ad_out, data_rd, ad_out2, data_rd2;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, fin, busy;
  logic       ad_oe2, cs_n2, rd_n2, wr_n2, a_d2, fin2, busy2;
  logic [3:0] dbg_state, dbg_state2;

  int checks = 0;
  int failures = 0;
  logic fin_seen;

  always #5 clk = ~clk;

  rtc_bus_driver dut (
    .clk(clk), .reset(reset), .activa(activa), .escribe(escribe),
    .dir_in(dir_in), .data_in(data_in), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .a_d(a_d), .data_rd(data_rd), .fin(fin), .busy(busy), .dbg_state(dbg_state)
  );

  rtc_bus_driver #(.T_SU(1), .T_PW(1), .T_HD(1), .T_REC(2)) dut2 (
    .clk(clk), .reset(reset), .activa(activa2), .escribe(escribe),
    .dir_in(dir_in), .data_in(data_in), .ad_in(ad_in),
    .ad_out(ad_out2), .ad_oe(ad_oe2), .cs_n(cs_n2), .rd_n(rd_n2), .wr_n(wr_n2),
    .a_d(a_d2), .data_rd(data_rd2), .fin(fin2), .busy(busy2), .dbg_state(dbg_state2)
  );

  // Packed order: cs_n wr_n rd_n a_d ad_oe fin busy ad_out data_rd
  typedef struct {
    logic        act;
    logic [7:0]  adi;
    logic [22:0] exp;
  } vec_t;

  vec_t tab[16];

  localparam logic [22:0] RST_VAL = {7'b1110000, 8'h00, 8'h00};

  function automatic logic [22:0] mk(input logic [6:0] ctl, input logic [7:0] o, input logic [7:0] d);
    return {ctl, o, d};
  endfunction

  function automatic logic [22:0] pack1();
    return {cs_n, wr_n, rd_n, a_d, ad_oe, fin, busy, ad_out, data_rd};
  endfunction

  function automatic logic [22:0] pack2();
    return {cs_n2, wr_n2, rd_n2, a_d2, ad_oe2, fin2, busy2, ad_out2, data_rd2};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fin) fin_seen = 1'b1;
  endtask

  task automatic run_tab(input string nm);
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("%s_c%0d", nm, k + 1), 32'(pack1()), 32'(tab[k].exp));
      activa = tab[k].act;
      ad_in  = tab[k].adi;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; activa = 1'b0; activa2 = 1'b0; escribe = 1'b0;
    dir_in = 8'h00; data_in = 8'h00; ad_in = 8'h5A; fin_seen = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("reset_dut1", 32'(pack1()), 32'(RST_VAL));
    chk("reset_dut2", 32'(pack2()), 32'(RST_VAL));
    chk("reset_state", 32'(dbg_state), 32'd0);

    // Write with default timing: addr 0x21, data 0x45
    dir_in = 8'h21; data_in = 8'h45; escribe = 1'b1; activa = 1'b1;
    tab[0]  = '{1'b1, 8'h5A, mk(7'b0110101, 8'h21, 8'h00)};
    tab[1]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h21, 8'h00)};
    tab[2]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h21, 8'h00)};
    tab[3]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h21, 8'h00)};
    tab[4]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h21, 8'h00)};
    tab[5]  = '{1'b1, 8'h5A, mk(7'b0110101, 8'h21, 8'h00)};
    tab[6]  = '{1'b1, 8'h5A, mk(7'b0111101, 8'h45, 8'h00)};
    tab[7]  = '{1'b1, 8'h5A, mk(7'b0011101, 8'h45, 8'h00)};
    tab[8]  = '{1'b1, 8'h5A, mk(7'b0011101, 8'h45, 8'h00)};
    tab[9]  = '{1'b1, 8'h5A, mk(7'b0011101, 8'h45, 8'h00)};
    tab[10] = '{1'b1, 8'h5A, mk(7'b0011101, 8'h45, 8'h00)};
    tab[11] = '{1'b1, 8'h5A, mk(7'b0111101, 8'h45, 8'h00)};
    tab[12] = '{1'b0, 8'h5A, mk(7'b1110011, 8'h00, 8'h00)};
    tab[13] = '{1'b0, 8'h5A, mk(7'b1110001, 8'h00, 8'h00)};
    tab[14] = '{1'b0, 8'h5A, mk(7'b1110001, 8'h00, 8'h00)};
    tab[15] = '{1'b0, 8'h5A, mk(7'b1110000, 8'h00, 8'h00)};
    run_tab("wr");

    // Read from 0x42; pad shows 0x37 only while RD# is low
    dir_in = 8'h42; data_in = 8'hEE; escribe = 1'b0; activa = 1'b1;
    tab[0]  = '{1'b1, 8'h5A, mk(7'b0110101, 8'h42, 8'h00)};
    tab[1]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h42, 8'h00)};
    tab[2]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h42, 8'h00)};
    tab[3]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h42, 8'h00)};
    tab[4]  = '{1'b1, 8'h5A, mk(7'b0010101, 8'h42, 8'h00)};
    tab[5]  = '{1'b1, 8'h5A, mk(7'b0110101, 8'h42, 8'h00)};
    tab[6]  = '{1'b1, 8'h5A, mk(7'b0111001, 8'h00, 8'h00)};
    tab[7]  = '{1'b1, 8'h37, mk(7'b0101001, 8'h00, 8'h00)};
    tab[8]  = '{1'b1, 8'h37, mk(7'b0101001, 8'h00, 8'h00)};
    tab[9]  = '{1'b1, 8'h37, mk(7'b0101001, 8'h00, 8'h00)};
    tab[10] = '{1'b1, 8'h37, mk(7'b0101001, 8'h00, 8'h00)};
    tab[11] = '{1'b1, 8'h5A, mk(7'b0111001, 8'h00, 8'h37)};
    tab[12] = '{1'b0, 8'h5A, mk(7'b1110011, 8'h00, 8'h37)};
    tab[13] = '{1'b0, 8'h5A, mk(7'b1110001, 8'h00, 8'h37)};
    tab[14] = '{1'b0, 8'h5A, mk(7'b1110001, 8'h00, 8'h37)};
    tab[15] = '{1'b0, 8'h5A, mk(7'b1110000, 8'h00, 8'h37)};
    run_tab("rd");

    // Chained: activa held; inputs changed mid-transaction are ignored
    dir_in = 8'h10; data_in = 8'h55; escribe = 1'b1; activa = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 2) begin dir_in = 8'h99; data_in = 8'h77; end
      if (k == 7) chk("chain_data1", 32'({a_d, ad_out}), 32'({1'b1, 8'h55}));
      if (k == 13) begin
        chk("chain_fin1", 32'(fin), 32'd1);
        dir_in = 8'hF2; data_in = 8'hF2;
      end
      if (k == 14 || k == 15) chk($sformatf("chain_quiet_c%0d", k), 32'({cs_n, ad_oe, fin}), 32'(3'b100));
      if (k == 16) chk("chain_idle", 32'({busy, cs_n}), 32'(2'b01));
      if (k == 17) chk("chain_addr2", 32'({cs_n, a_d, ad_out}), 32'({1'b0, 1'b0, 8'hF2}));
      if (k == 23) chk("chain_data2", 32'({cs_n, a_d, ad_out}), 32'({1'b0, 1'b1, 8'hF2}));
      if (k == 29) begin
        chk("chain_fin2", 32'(fin), 32'd1);
        activa = 1'b0;
      end
      if (k == 32) chk("chain_end", 32'(busy), 32'd0);
    end

    // Abort during A_PW, then a restart held off by recovery
    dir_in = 8'h33; data_in = 8'h44; escribe = 1'b1; activa = 1'b1; fin_seen = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 3) begin
        chk("abort_pw", 32'(wr_n), 32'd0);
        activa = 1'b0;
      end
      if (k == 4) begin
        chk("abort_bus", 32'({wr_n, cs_n, ad_oe, fin, busy}), 32'(5'b11001));
        activa = 1'b1;
      end
      if (k == 5) chk("abort_rec", 32'(cs_n), 32'd1);
      if (k == 6) chk("abort_idle", 32'({busy, cs_n}), 32'(2'b01));
      if (k == 7) chk("abort_restart", 32'({cs_n, ad_out}), 32'({1'b0, 8'h33}));
    end
    activa = 1'b0;
    wait_idle("abort_settle");
    chk("abort_no_fin", 32'(fin_seen), 32'd0);
    chk("abort_data_rd", 32'(data_rd), 32'h37);

    // Reset in the middle of a write data strobe
    dir_in = 8'h66; data_in = 8'h77; escribe = 1'b1; activa = 1'b1; fin_seen = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    chk("rstmid_pw", 32'({a_d, wr_n}), 32'(2'b10));
    reset = 1'b1;
    step();
    chk("rstmid_vals", 32'(pack1()), 32'(RST_VAL));
    reset = 1'b0; activa = 1'b0;
    repeat (4) step();
    chk("rstmid_no_fin", 32'(fin_seen), 32'd0);
    chk("rstmid_idle", 32'(busy), 32'd0);

    // Minimum timing instance: L=3, fin at E0+7
    dir_in = 8'h5C; data_in = 8'hA3; escribe = 1'b1; activa2 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("min_wr_c%0d", k), 32'(wr_n2), 32'((k == 2 || k == 5) ? 1'b0 : 1'b1));
      chk($sformatf("min_fin_c%0d", k), 32'(fin2), 32'((k == 7) ? 1'b1 : 1'b0));
      if (k == 4) chk("min_data", 32'({a_d2, ad_out2}), 32'({1'b1, 8'hA3}));
      if (k == 7) activa2 = 1'b0;
      if (k == 10) chk("min_idle", 32'(busy2), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_bus_driver.md
# rtc_bus_driver

Cycle-level bus timing generator between the RTC write/read sequencer and the RTC chip's multiplexed address/data port (Intel-style: CS#, RD#, WR#, A/D#, AD[7:0]). It accepts a request level (`activa`, `escribe`, address, data) and runs one complete transaction: address phase, then data phase (write or read). It then pulses `fin` for one cycle and enforces a recovery gap. The gap lets the upstream sequencer advance and present its next request, for example the 0xF0/0xF2 transfer command that follows a register write.

## Interface
- T_SU, default 1: setup cycles per phase, range 1..15
- T_PW, default 4: strobe (RD#/WR# low) cycles per phase, range 1..15
- T_HD, default 1: hold cycles per phase, range 1..15
- T_REC, default 2: recovery cycles after `fin`, range 2..15
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- activa  in  1  request level; transaction starts when sampled high in IDLE
- escribe  in  1  1 = write data phase, 0 = read data phase
- dir_in  in  8  register address
- data_in  in  8  write data
- ad_in  in  8  AD bus value from pad
- ad_out  out  8  AD bus drive value
- ad_oe  out  1  AD pad output enable
- cs_n  out  1  chip select, active-low
- rd_n  out  1  read strobe, active-low
- wr_n  out  1  write strobe, active-low
- a_d  out  1  0 = address phase, 1 = data phase
- data_rd  out  8  last captured read byte
- fin  out  1  one-cycle transaction-complete pulse
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: ad_out=0x00, ad_oe=0, cs_n=1, rd_n=1, wr_n=1, a_d=0, data_rd=0x00, fin=0, busy=0, state=IDLE, counter=0.
- All outputs are registered. One 4-bit phase counter is loaded with (length−1) on every state entry.
- States and outputs:
  - IDLE: bus inactive. If activa=1, latch dir_in, data_in and escribe, then go to A_SU.
  - A_SU (T_SU cycles): cs_n=0, a_d=0, ad_oe=1, ad_out=latched dir.
  - A_PW (T_PW cycles): as A_SU, plus wr_n=0. The address is always latched with WR#.
  - A_HD (T_HD cycles): as A_SU, with wr_n=1.
  - D_SU (T_SU cycles): cs_n=0, a_d=1.
    - Write: ad_oe=1, ad_out=latched data.
    - Read: ad_oe=0, ad_out=0x00.
  - D_PW (T_PW cycles): as D_SU, plus wr_n=0 (write) or rd_n=0 (read). Read: data_rd <= ad_in on the final D_PW cycle.
  - D_HD (T_HD cycles): as D_SU, with strobes high.
  - DONE (1 cycle): bus inactive (cs_n=1, ad_oe=0, a_d=0), fin=1.
  - REC (T_REC cycles): bus inactive, fin=0, activa ignored. Then go to IDLE.
- Request inputs are sampled only in IDLE. Changes to dir_in, data_in or escribe during a transaction have no effect.
- If activa stays high after REC, a new transaction starts from IDLE with freshly sampled inputs. This is how back-to-back sequencer phases chain.
- Abort: activa=0 in any state from A_SU to D_HD causes, on the next edge, all strobes high, cs_n=1, ad_oe=0, no fin, and entry to REC. data_rd is not updated by an aborted read.
- reset has priority over everything, in any state.
- data_rd holds its value until the next completed read.

## Timing
- Let L = T_SU+T_PW+T_HD.
- Acceptance edge is E0, where activa=1 is sampled in IDLE. First bus cycle (cs_n=0) is E0+1.
- Address phase occupies E0+1 .. E0+L. Data phase occupies E0+L+1 .. E0+2L.
- fin is high for exactly one cycle, E0+2L+1. The earliest next acceptance edge is E0+2L+2+T_REC.
- Defaults: L=6. cs_n low for 12 cycles, fin at E0+13, next start at E0+16.
- wr_n/rd_n never go low in the same cycle that a_d or ad_out changes. Setup and hold are at least 1 cycle by parameter range.
- busy rises at E0+1 and falls on IDLE re-entry.

## Test plan
- Write, defaults: dir_in=0x21, data_in=0x45, escribe=1, activa pulse held.
  - Expect address 0x21 with a_d=0 and wr_n low for E0+2..E0+5.
  - Expect data 0x45 with a_d=1 and wr_n low for E0+8..E0+11.
  - Expect fin only at E0+13.
- Read: dir_in=0x42, escribe=0, ad_in=0x37 during D_PW.
  - Expect ad_oe=0 in the data phase and rd_n low for 4 cycles.
  - Expect data_rd=0x37 after D_PW; wr_n high throughout the data phase.
- Chained: hold activa=1, change dir_in/data_in to 0xF2/0xF2 the cycle after fin.
  - Expect a second transaction driving 0xF2/0xF2 starting E0+16.
  - Expect no bus activity during E0+14..E0+15.
- Abort: drop activa during the A_PW cycle (E0+3).
  - Expect wr_n=1, cs_n=1, ad_oe=0 at E0+4, no fin, and data_rd unchanged.
  - Expect a restart only after T_REC cycles.
- Reset mid-D_PW on a write: expect all outputs at reset values on the next edge and fin never asserted.
- Parameters T_SU=T_PW=T_HD=1, T_REC=2: expect fin at E0+7 and strobes exactly 1 cycle wide.
